// File: rtl/wr_ctl_af.sv
// Write-side pointer and flag controller of a dual-clock FIFO.
// Owns the binary/Gray write pointers, read-pointer synchroniser, full, almost-full, fill count and sticky overflow.
module wr_ctl_af #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned ALMOST_FULL_TH = 252
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_en,
  input  logic [FIFO_DEPTH:0]   rd_addr_glay,
  output logic                  wr_ram_en,
  output logic [FIFO_DEPTH-1:0] wr_addr_bin,
  output logic [FIFO_DEPTH:0]   wr_addr_glay,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [FIFO_DEPTH:0]   wr_count,
  output logic                  wr_overflow
);

  localparam int unsigned PW = FIFO_DEPTH + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rq1_q, rq2_q;
  logic [PW-1:0] rbin;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          accept;

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all bits from the MSB down to i.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin[i] = ^(rq2_q >> i);
    end
  end

  // Next-state: write advance, Gray encode, full/almost-full/count against the synchronised read pointer.
  always_comb begin
    accept  = wr_en & ~full_q;
    wbin_d  = wbin_q + PW'(accept);
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    full_d  = (wgray_d == {~rq2_q[PW-1:PW-2], rq2_q[PW-3:0]});
    count_d = wbin_d - rbin;
    afull_d = (32'(count_d) >= ALMOST_FULL_TH);
    ovf_d   = ovf_q | (wr_en & full_q);
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rd_addr_glay;
      rq2_q   <= rq1_q;
      count_q <= count_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_ram_en      = accept;
  assign wr_addr_bin    = wbin_q[FIFO_DEPTH-1:0];
  assign wr_addr_glay   = wgray_q;
  assign wr_full        = full_q;
  assign wr_almost_full = afull_q;
  assign wr_count       = count_q;
  assign wr_overflow    = ovf_q;

endmodule

// File: tb/tb_wr_ctl_af.sv
// Self-checking bench for wr_ctl_af: occupancy-based reference model feeding an expected-result queue.
module tb_wr_ctl_af;

  logic       wr_clk = 1'b0;
  logic       wr_rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [8:0] rd_addr_glay = '0;
  logic       wr_ram_en;
  logic [7:0] wr_addr_bin;
  logic [8:0] wr_addr_glay;
  logic       wr_full;
  logic       wr_almost_full;
  logic [8:0] wr_count;
  logic       wr_overflow;

  wr_ctl_af #(.FIFO_DEPTH(8), .ALMOST_FULL_TH(252)) dut (
    .wr_clk         (wr_clk),
    .wr_rst         (wr_rst),
    .wr_en          (wr_en),
    .rd_addr_glay   (rd_addr_glay),
    .wr_ram_en      (wr_ram_en),
    .wr_addr_bin    (wr_addr_bin),
    .wr_addr_glay   (wr_addr_glay),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_count       (wr_count),
    .wr_overflow    (wr_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [8:0] glay;
    logic       full;
    logic       af;
    logic [8:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t got;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model in occupancy terms: writes done, read pointer seen through a two-stage delay.
  int   m_w = 0, m_rq1 = 0, m_rq2 = 0;
  logic m_full = 1'b0, m_ovf = 1'b0;

  function automatic logic [8:0] gray9(input int v);
    logic [8:0] b;
    b = 9'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s = '{addr: wr_addr_bin, glay: wr_addr_glay, full: wr_full, af: wr_almost_full,
          cnt: wr_count, ovf: wr_overflow};
    return s;
  endfunction

  // Drive one cycle, check the combinational strobe, push the post-edge expectation, advance past the edge.
  task automatic step(input logic en, input int rd, input logic rst);
    exp_t x;
    logic acc;
    int   wn, cnt;
    wr_en = en;
    wr_rst = rst;
    rd_addr_glay = gray9(rd);
    #1;
    n_cmp++;
    if (wr_ram_en !== (en & ~m_full)) begin
      n_bad++;
      $display("FAIL ram_en: got %b want %b", wr_ram_en, en & ~m_full);
    end
    if (rst) begin
      x = '0;
      m_w = 0; m_rq1 = 0; m_rq2 = 0; m_full = 1'b0; m_ovf = 1'b0;
    end else begin
      acc    = en & ~m_full;
      wn     = (m_w + int'(acc)) % 512;
      cnt    = (wn - m_rq2 + 512) % 512;
      x.addr = 8'(wn % 256);
      x.glay = gray9(wn);
      x.cnt  = 9'(cnt);
      x.full = (cnt == 256);
      x.af   = (cnt >= 252);
      x.ovf  = m_ovf | (en & m_full);
      m_rq2  = m_rq1;
      m_rq1  = rd;
      m_w    = wn;
      m_full = x.full;
      m_ovf  = x.ovf;
    end
    sb.push_back(x);
    @(posedge wr_clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    e = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_state: got %h want %h", got, e); end
    wr_rst = 1'b0; wr_en = 1'b1; #1; n_cmp++;
    if (wr_ram_en !== 1'b1) begin n_bad++; $display("FAIL reset_ram_en: got %b want 1", wr_ram_en); end
    wr_en = 1'b0;
    sb.delete();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 0, 1'b0);
      e = sb.pop_front(); got = sample(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL fill[%0d]: got %h want %h", i, got, e); end
    end
    n_cmp++;
    if ({wr_full, wr_count, wr_addr_bin, wr_addr_glay} !== {1'b1, 9'd256, 8'd0, 9'h180}) begin
      n_bad++;
      $display("FAIL full_after_256: full=%b cnt=%0d addr=%0d glay=%h want 1/256/0/180",
               wr_full, wr_count, wr_addr_bin, wr_addr_glay);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      step(i < 3, 0, 1'b0);
      e = sb.pop_front(); got = sample(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL overflow[%0d]: got %h want %h", i, got, e); end
    end
    n_cmp++;
    if ({wr_overflow, wr_addr_bin, wr_addr_glay} !== {1'b1, 8'd0, 9'h180}) begin
      n_bad++;
      $display("FAIL overflow_sticky: ovf=%b addr=%0d glay=%h want 1/0/180", wr_overflow, wr_addr_bin, wr_addr_glay);
    end
  endtask

  task automatic test_release();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4, 1'b0);
      e = sb.pop_front(); got = sample(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL release[%0d]: got %h want %h", i, got, e); end
    end
    n_cmp++;
    if ({wr_full, wr_count, wr_almost_full} !== {1'b0, 9'd252, 1'b1}) begin
      n_bad++;
      $display("FAIL release_third_edge: full=%b cnt=%0d af=%b want 0/252/1", wr_full, wr_count, wr_almost_full);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4, 1'b0);
      e = sb.pop_front(); got = sample(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL refill[%0d]: got %h want %h", i, got, e); end
    end
    n_cmp++;
    if (wr_full !== 1'b1) begin n_bad++; $display("FAIL refull: got %b want 1", wr_full); end
  endtask

  task automatic test_wrap();
    logic [8:0] prev;
    int         tot;
    step(1'b0, 0, 1'b1);
    void'(sb.pop_front());
    tot = 0;
    for (int i = 0; i < 1100; i++) begin
      prev = wr_addr_glay;
      step(1'b1, (tot >= 4) ? (tot - 4) % 512 : 0, 1'b0);
      tot++;
      e = sb.pop_front(); got = sample(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL wrap[%0d]: got %h want %h", i, got, e); end
      n_cmp++;
      if ($countones(prev ^ wr_addr_glay) != 1 || wr_full !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap_gray[%0d]: %h->%h full=%b want one-bit change, full 0", i, prev, wr_addr_glay, wr_full);
      end
    end
  endtask

  task automatic test_midreset();
    step(1'b0, 0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 0, 1'b0);
      void'(sb.pop_front());
    end
    n_cmp++;
    if (wr_count !== 9'd100) begin n_bad++; $display("FAIL pre_reset_count: got %0d want 100", wr_count); end
    step(1'b1, 0, 1'b1);
    e = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== e || got !== '0) begin n_bad++; $display("FAIL midreset: got %h want 0", got); end
    step(1'b1, 0, 1'b0);
    e = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL after_reset_write: got %h want %h", got, e); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
